// File: rtl/router_pkg.sv
// Shared constants and helpers for the router register stage: check-mode
// selectors, the CRC-8 step function and header address extraction.
package router_pkg;

  localparam int CHK_XOR  = 0;
  localparam int CHK_CRC8 = 1;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // One byte of MSB-first CRC-8 (poly 0x07), no reflection, no final xor.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

  function automatic int unsigned hdr_addr(input logic [31:0] data, input int unsigned addr_w);
    logic [31:0] mask;
    mask = (32'd1 << addr_w) - 32'd1;
    return data & mask;
  endfunction

endpackage

// File: rtl/router_hold_fifo.sv
// Small circular hold buffer that absorbs FIFO back-pressure. Head is visible
// combinationally so the caller can register it onto its output bus.
module router_hold_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = mem[rd_q];

  // A push into a full buffer only lands when a pop frees the head slot.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = ptr_inc(wr_q);
    if (do_pop)  rd_d = ptr_inc(rd_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

endmodule

// File: rtl/router_reg_gen.sv
// Router datapath register stage: header capture, payload forwarding with a
// tagged hold buffer for back-pressure, packet check and error counting.
module router_reg_gen
  import router_pkg::*;
#(
  parameter int DW         = 8,
  parameter int ADDR_W     = 2,
  parameter int N_DEST     = 3,
  parameter int HOLD_DEPTH = 2,
  parameter int CHK_MODE   = 0,
  parameter int ERR_CNT_W  = 8,
  localparam int CNT_W     = $clog2(HOLD_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic                 fifo_full,
  input  logic                 rst_int_reg,
  input  logic                 detect_add,
  input  logic                 lfd_state,
  input  logic                 ld_state,
  input  logic                 laf_state,
  input  logic                 full_state,
  input  logic [DW-1:0]        data_in,
  output logic [DW-1:0]        dout,
  output logic                 dout_valid,
  output logic                 parity_done,
  output logic                 low_pkt_valid,
  output logic                 err,
  output logic [CNT_W-1:0]     hold_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [DW-1:0]        header_q, header_d, acc_q, acc_d, chk_q, chk_d, dout_q, dout_d;
  logic                 ovf_q, ovf_d, dout_valid_q, dout_valid_d, parity_done_q, parity_done_d;
  logic                 low_pkt_valid_q, low_pkt_valid_d, err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic          push, pop, hold_full, hold_empty, drop, do_fold, parity_out;
  logic [DW:0]   push_data, head;
  logic [DW-1:0] fold_byte, fold_res, parity_chk;
  logic          unused_full_state;

  assign unused_full_state = full_state;

  router_hold_fifo #(.W(DW + 1), .DEPTH(HOLD_DEPTH)) u_hold (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (push_data),
    .head   (head),
    .count  (hold_cnt),
    .full   (hold_full),
    .empty  (hold_empty)
  );

  generate
    if (CHK_MODE == CHK_CRC8) begin : g_crc
      assign fold_res = DW'(crc8_next(8'(acc_q), 8'(fold_byte)));
    end else begin : g_xor
      assign fold_res = acc_q ^ fold_byte;
    end
  endgenerate

  always_comb begin
    header_d        = header_q;
    acc_d           = acc_q;
    chk_d           = chk_q;
    ovf_d           = ovf_q;
    dout_d          = dout_q;
    dout_valid_d    = 1'b0;
    parity_done_d   = 1'b0;
    low_pkt_valid_d = low_pkt_valid_q;
    err_d           = err_q;
    err_cnt_d       = err_cnt_q;
    push            = 1'b0;
    pop             = 1'b0;
    push_data       = {!pkt_valid, data_in};
    fold_byte       = data_in;
    do_fold         = 1'b0;
    parity_out      = 1'b0;
    parity_chk      = chk_q;

    if (detect_add) begin
      if (pkt_valid && hdr_addr(32'(data_in), ADDR_W) < N_DEST) header_d = data_in;
      acc_d           = '0;
      chk_d           = '0;
      err_d           = 1'b0;
      ovf_d           = 1'b0;
      low_pkt_valid_d = 1'b0;
    end

    if (lfd_state) begin
      dout_d       = header_q;
      dout_valid_d = 1'b1;
      fold_byte    = header_q;
      do_fold      = 1'b1;
    end else if (ld_state) begin
      push = fifo_full || !hold_empty;
      pop  = !fifo_full && !hold_empty;
      if (!fifo_full) begin
        dout_valid_d = 1'b1;
        if (hold_empty) begin
          dout_d     = data_in;
          parity_out = !pkt_valid;
          parity_chk = data_in;
        end else begin
          dout_d     = head[DW-1:0];
          parity_out = head[DW];
        end
      end
      if (pkt_valid && !drop) do_fold = 1'b1;
      if (!pkt_valid) begin
        chk_d           = data_in;
        low_pkt_valid_d = 1'b1;
      end
    end else if (laf_state && !fifo_full && !hold_empty) begin
      pop          = 1'b1;
      dout_d       = head[DW-1:0];
      dout_valid_d = 1'b1;
      parity_out   = head[DW];
    end

    if (drop)        ovf_d           = 1'b1;
    if (do_fold)     acc_d           = fold_res;
    if (rst_int_reg) low_pkt_valid_d = 1'b0;

    // Verdict is taken when the parity byte actually leaves on dout.
    if (parity_out) begin
      parity_done_d = 1'b1;
      err_d         = (acc_q != parity_chk) || ovf_q;
      if (err_d && err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign drop = push && !pop && hold_full;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      header_q        <= '0;
      acc_q           <= '0;
      chk_q           <= '0;
      ovf_q           <= 1'b0;
      dout_q          <= '0;
      dout_valid_q    <= 1'b0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
      err_cnt_q       <= '0;
    end else begin
      header_q        <= header_d;
      acc_q           <= acc_d;
      chk_q           <= chk_d;
      ovf_q           <= ovf_d;
      dout_q          <= dout_d;
      dout_valid_q    <= dout_valid_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
      err_cnt_q       <= err_cnt_d;
    end
  end

  assign dout          = dout_q;
  assign dout_valid    = dout_valid_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_router_reg_gen.sv
// Scoreboard bench: directed packets push expected dout beats; a negedge
// monitor pops and compares every dout_valid beat of the XOR instance.
module tb_router_reg_gen;

  logic       clk = 1'b0;
  logic       resetn, pkt_valid, fifo_full, rst_int_reg;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic [7:0] data_in;

  logic [7:0] x_dout, c_dout, x_err_cnt, c_err_cnt;
  logic [1:0] x_hold_cnt, c_hold_cnt;
  logic       x_dv, x_pd, x_low, x_err, c_dv, c_pd, c_low, c_err;

  typedef struct packed {logic [7:0] d; logic pd; logic e;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  router_reg_gen #(.CHK_MODE(0)) u_xor (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .rst_int_reg(rst_int_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .data_in(data_in), .dout(x_dout), .dout_valid(x_dv), .parity_done(x_pd),
    .low_pkt_valid(x_low), .err(x_err), .hold_cnt(x_hold_cnt), .err_cnt(x_err_cnt)
  );

  router_reg_gen #(.CHK_MODE(1)) u_crc (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .rst_int_reg(rst_int_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .data_in(data_in), .dout(c_dout), .dout_valid(c_dv), .parity_done(c_pd),
    .low_pkt_valid(c_low), .err(c_err), .hold_cnt(c_hold_cnt), .err_cnt(c_err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1 && x_dv === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dout actual=%0h required=no_beat", x_dout);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("dout", 32'(x_dout), 32'(e.d));
        chk("parity_done", 32'(x_pd), 32'(e.pd));
        if (e.pd) chk("err_at_parity", 32'(x_err), 32'(e.e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    pkt_valid = 0; fifo_full = 0; rst_int_reg = 0; detect_add = 0;
    lfd_state = 0; ld_state = 0; laf_state = 0; full_state = 0; data_in = 8'h00;
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic pd, input logic e);
    q.push_back('{d: d, pd: pd, e: e});
  endtask

  task automatic det(input logic [7:0] h);
    clr(); detect_add = 1; pkt_valid = 1; data_in = h; step(); clr();
  endtask

  task automatic lfd(input logic [7:0] exp_hdr);
    expect_beat(exp_hdr, 0, 0);
    clr(); lfd_state = 1; pkt_valid = 1; step(); clr();
  endtask

  task automatic ld(input logic [7:0] b, input logic pv, input logic full);
    clr(); ld_state = 1; pkt_valid = pv; fifo_full = full; data_in = b; step(); clr();
  endtask

  task automatic laf();
    clr(); laf_state = 1; step(); clr();
  endtask

  initial begin
    clr();
    resetn = 0;
    step(); step();
    chk("rst_dout", 32'(x_dout), 0);
    chk("rst_dout_valid", 32'(x_dv), 0);
    chk("rst_hold_cnt", 32'(x_hold_cnt), 0);
    chk("rst_err", 32'(x_err), 0);
    chk("rst_err_cnt", 32'(x_err_cnt), 0);
    chk("rst_low_pkt_valid", 32'(x_low), 0);
    resetn = 1;
    step();

    // good XOR packet
    det(8'h01); lfd(8'h01);
    expect_beat(8'hAA, 0, 0); ld(8'hAA, 1, 0);
    expect_beat(8'h55, 0, 0); ld(8'h55, 1, 0);
    expect_beat(8'hFE, 1, 0); ld(8'hFE, 0, 0);
    step();
    chk("t1_low_pkt_valid", 32'(x_low), 1);
    chk("t1_err", 32'(x_err), 0);
    chk("t1_err_cnt", 32'(x_err_cnt), 0);
    rst_int_reg = 1; step(); clr();
    chk("t1_low_cleared", 32'(x_low), 0);

    // bad parity
    det(8'h01); lfd(8'h01);
    expect_beat(8'hAA, 0, 0); ld(8'hAA, 1, 0);
    expect_beat(8'h55, 0, 0); ld(8'h55, 1, 0);
    expect_beat(8'h00, 1, 1); ld(8'h00, 0, 0);
    step();
    chk("t2_err", 32'(x_err), 1);
    chk("t2_err_cnt", 32'(x_err_cnt), 1);

    // back-pressure absorbed in the hold buffer
    det(8'h01);
    chk("t2_err_cleared", 32'(x_err), 0);
    lfd(8'h01);
    ld(8'hAA, 1, 1);
    chk("t3_hold1", 32'(x_hold_cnt), 1);
    ld(8'h55, 1, 1);
    chk("t3_hold2", 32'(x_hold_cnt), 2);
    expect_beat(8'hAA, 0, 0); ld(8'hFE, 0, 0);
    chk("t3_hold_pushpop", 32'(x_hold_cnt), 2);
    expect_beat(8'h55, 0, 0); laf();
    chk("t3_hold_pop1", 32'(x_hold_cnt), 1);
    expect_beat(8'hFE, 1, 0); laf();
    chk("t3_hold_pop2", 32'(x_hold_cnt), 0);
    step();
    chk("t3_err_cnt", 32'(x_err_cnt), 1);

    // overflow: third push dropped, err despite correct parity
    det(8'h01); lfd(8'h01);
    ld(8'hAA, 1, 1);
    ld(8'h55, 1, 1);
    ld(8'h11, 1, 1);
    chk("t4_hold_sat", 32'(x_hold_cnt), 2);
    expect_beat(8'hAA, 0, 0); ld(8'hFE, 0, 0);
    expect_beat(8'h55, 0, 0); laf();
    expect_beat(8'hFE, 1, 1); laf();
    step();
    chk("t4_err_cnt", 32'(x_err_cnt), 2);

    // CRC-8 instance: 01,02 -> 1B good; XOR instance sees 03 vs 1B
    det(8'h01); lfd(8'h01);
    expect_beat(8'h02, 0, 0); ld(8'h02, 1, 0);
    expect_beat(8'h1B, 1, 1); ld(8'h1B, 0, 0);
    chk("t5_crc_parity_done", 32'(c_pd), 1);
    chk("t5_crc_dout", 32'(c_dout), 32'h1B);
    chk("t5_crc_err_good", 32'(c_err), 0);
    step();
    chk("t5_err_cnt", 32'(x_err_cnt), 3);
    det(8'h01); lfd(8'h01);
    expect_beat(8'h02, 0, 0); ld(8'h02, 1, 0);
    expect_beat(8'h1C, 1, 1); ld(8'h1C, 0, 0);
    chk("t5_crc_parity_done2", 32'(c_pd), 1);
    chk("t5_crc_err_bad", 32'(c_err), 1);
    step();
    chk("t5b_err_cnt", 32'(x_err_cnt), 4);

    // async reset mid-payload with a full hold buffer
    lfd(8'h01);
    ld(8'hAA, 1, 1);
    ld(8'h55, 1, 1);
    chk("t6_hold_before", 32'(x_hold_cnt), 2);
    chk("t6_err_before", 32'(x_err), 1);
    ld_state = 1; pkt_valid = 1; fifo_full = 1; data_in = 8'h77;
    #2 resetn = 0;
    #1;
    chk("t6_rst_dout", 32'(x_dout), 0);
    chk("t6_rst_hold_cnt", 32'(x_hold_cnt), 0);
    chk("t6_rst_err", 32'(x_err), 0);
    chk("t6_rst_low", 32'(x_low), 0);
    chk("t6_rst_err_cnt", 32'(x_err_cnt), 0);
    clr();
    step();
    resetn = 1;
    step();
    det(8'h03);
    lfd(8'h00);
    step(); step();
    chk("queue_drained", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_reg_gen.md
Name: router_reg_gen

Overview:
Parametrised successor of the router datapath register stage; sits between the router FSM and the per-destination output FIFOs. Captures the header, forwards payload to the FIFO write bus, and absorbs FIFO back-pressure in a HOLD_DEPTH-entry hold buffer instead of a single byte. Supports XOR or CRC-8 packet checking, sticky error reporting and a saturating error counter.

Parameters:
DW, 8, data/header width in bits (>=4)
ADDR_W, 2, header address field width (data_in[ADDR_W-1:0])
N_DEST, 3, legal destinations; header valid when address < N_DEST
HOLD_DEPTH, 2, hold-buffer entries (>=1)
CHK_MODE, 0, 0 = XOR parity, 1 = CRC-8 poly 0x07, init 0x00, MSB-first (legal only with DW=8)
ERR_CNT_W, 8, width of error counter

Ports:
clk  in  1  clock, rising edge
resetn  in  1  reset, asynchronous, active-low
pkt_valid  in  1  source packet valid
fifo_full  in  1  selected FIFO full
rst_int_reg  in  1  clears low_pkt_valid
detect_add, lfd_state, ld_state, laf_state, full_state  in  1 each  FSM state strobes
data_in  in  DW  source byte
dout  out  DW  FIFO write data
dout_valid  out  1  dout written on this edge (one-cycle pulse)
parity_done  out  1  check complete (one-cycle pulse)
low_pkt_valid  out  1  parity byte received
err  out  1  check failed (sticky per packet)
hold_cnt  out  $clog2(HOLD_DEPTH+1)  hold-buffer occupancy
err_cnt  out  ERR_CNT_W  saturating count of failed packets

Behaviour:
- Reset (async, any time incl. mid-packet): all outputs, header, check accumulator, packet check byte, hold pointers/count, overflow flag = 0. Hold buffer contents don't-care.
- All outputs registered; one-cycle latency from strobe to output.
- Header: detect_add && pkt_valid && address < N_DEST -> header <= data_in; illegal address: header unchanged.
- detect_add: clears accumulator, check byte, err, overflow flag, low_pkt_valid.
- dout priority (first match): lfd_state -> dout<=header; ld_state && !fifo_full && hold empty -> dout<=data_in; ld_state && !fifo_full && hold non-empty -> dout<=hold head, push data_in (count unchanged, order preserved); ld_state && fifo_full -> push data_in, dout held; laf_state && !fifo_full && hold non-empty -> pop head to dout. dout_valid=1 the cycle after any dout write, else 0.
- Push when hold full: byte dropped, overflow flag set (sticky), count unchanged.
- ld_state and laf_state both high: ld_state rules apply, no extra pop.
- Each hold entry carries a tag bit = 1 for the parity byte (!pkt_valid at push).
- Accumulator: lfd_state folds header; every payload byte accepted in ld_state with pkt_valid (direct or pushed, not dropped) folded. XOR mode: acc^=byte; CRC mode: CRC-8 update. Parity byte is never folded.
- ld_state && !pkt_valid: check byte <= data_in; low_pkt_valid <= 1; sticky until rst_int_reg (priority) or detect_add.
- parity_done pulses the cycle the parity byte reaches dout (direct write or tagged entry popped). Same edge: err <= (acc != check byte) || overflow; err_cnt += 1 if err, saturating at all-ones. err holds until next detect_add.
- full_state has no effect on this block beyond the FSM strobes above.

Decomposition:
- Package router_pkg: CHK_XOR/CHK_CRC8 mode constants, CRC8_POLY=8'h07, crc8_next() function, header address extraction function.
- Sub-module router_hold_fifo (DW+1 wide, HOLD_DEPTH deep, push/pop/simultaneous, count, full/empty); top holds header/check/err logic.

Test Plan:
- XOR, header 8'h01, payload 8'hAA,8'h55, parity 8'hFE, fifo_full=0 -> dout 01,AA,55,FE with dout_valid each; parity_done one pulse; err=0; err_cnt=0.
- Same packet, parity 8'h00 -> err=1 with parity_done; err_cnt=1; err clears on next detect_add.
- fifo_full=1 over 2 payload bytes, then laf_state, fifo_full=0 -> hold_cnt 1,2, then bytes popped in order; no dout_valid while full.
- HOLD_DEPTH=2, 3 pushes while full -> third dropped, hold_cnt=2, err=1 at parity_done despite correct parity.
- CHK_MODE=1, header 8'h01, payload 8'h02 -> CRC 8'h1B accepted err=0; parity 8'h1C -> err=1.
- resetn low mid-payload with hold_cnt=2 -> immediately dout=0, hold_cnt=0, err=0, low_pkt_valid=0; header 8'h03 with N_DEST=3 not captured.
